// File: rtl/serial_bus_sequencer_if.sv
// rtl/serial_bus_sequencer_if.sv - byte-wide serial bus signal bundle
interface serial_bus_sequencer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;

  // The sequencer owns the bus and drives the transmit side
  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  rx_data,
    input  rx_valid
  );

  // The bus endpoint accepts transmit bytes and returns receive bytes
  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output rx_data,
    output rx_valid
  );
endinterface

// File: rtl/serial_bus_sequencer.sv
// rtl/serial_bus_sequencer.sv - byte-serial bus transaction sequencer for fetch, read and write
module serial_bus_sequencer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fetch_req,
  input  logic [15:0]                   pc,
  input  logic                          mem_req,
  input  logic                          mem_we,
  input  logic [15:0]                   mem_addr,
  input  logic [15:0]                   mem_wdata,
  serial_bus_sequencer_if.master        bus,
  output logic                          instr_shift,
  input  logic                          instr_done,
  input  logic                          instr_halt,
  input  logic                          instr_err,
  output logic [15:0]                   mem_rdata,
  output logic                          fetch_done,
  output logic                          mem_done,
  output logic                          busy,
  output logic                          halted,
  output logic                          error
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_ADDR_LO,
    S_ADDR_HI,
    S_WDATA_LO,
    S_WDATA_HI,
    S_RECV,
    S_DONE,
    S_HALT,
    S_ERROR
  } state_t;

  // Operation codes double as the command byte sent on the bus
  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_FETCH = 2'd1,
    OP_READ  = 2'd2,
    OP_WRITE = 2'd3
  } op_t;

  // Timer value at which one more stalled cycle means the bus is dead
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  op_t         r_op;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;
  logic        r_rx_hi;
  logic [7:0]  r_timer;
  logic        w_accept;
  logic        w_stall;
  logic        w_tx_state;
  logic        w_rx_hs;
  logic        w_fetch;

  assign w_fetch    = (r_op == OP_FETCH);
  assign w_tx_state = (r_state == S_CMD) || (r_state == S_ADDR_LO) || (r_state == S_ADDR_HI) ||
                      (r_state == S_WDATA_LO) || (r_state == S_WDATA_HI);
  assign w_rx_hs    = (r_state == S_RECV) && bus.rx_valid;
  assign w_accept   = (r_state == S_IDLE) && (mem_req || fetch_req);

  // Next-state logic: advance on byte handshakes, flag stalled cycles for the timer
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_CMD;
      end
      S_CMD: begin
        if (bus.tx_ready) w_state_nxt = S_ADDR_LO;
        else              w_stall     = 1'b1;
      end
      S_ADDR_LO: begin
        if (bus.tx_ready) w_state_nxt = S_ADDR_HI;
        else              w_stall     = 1'b1;
      end
      S_ADDR_HI: begin
        if (bus.tx_ready) w_state_nxt = (r_op == OP_WRITE) ? S_WDATA_LO : S_RECV;
        else              w_stall     = 1'b1;
      end
      S_WDATA_LO: begin
        if (bus.tx_ready) w_state_nxt = S_WDATA_HI;
        else              w_stall     = 1'b1;
      end
      S_WDATA_HI: begin
        if (bus.tx_ready) w_state_nxt = S_DONE;
        else              w_stall     = 1'b1;
      end
      S_RECV: begin
        if (w_fetch) begin
          // Instruction register verdicts outrank each other: illegal, then halt, then complete
          if (instr_err)         w_state_nxt = S_ERROR;
          else if (instr_halt)   w_state_nxt = S_HALT;
          else if (instr_done)   w_state_nxt = S_DONE;
          else if (!bus.rx_valid) w_stall    = 1'b1;
        end else if (bus.rx_valid) begin
          if (r_rx_hi) w_state_nxt = S_DONE;
        end else begin
          w_stall = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = r_state;
      end
    endcase
    if (w_stall && (r_timer == TIMER_LAST)) w_state_nxt = S_ERROR;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Stall timer: counts consecutive stalled cycles, cleared by any progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                    r_timer <= 8'd0;
    else if (w_stall && (w_state_nxt == r_state)) r_timer <= r_timer + 8'd1;
    else                                         r_timer <= 8'd0;
  end

  // Operand capture on accept; a data access wins over a fetch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op    <= OP_NONE;
      r_addr  <= 16'd0;
      r_wdata <= 16'd0;
    end else if (w_accept) begin
      if (mem_req) begin
        r_op    <= mem_we ? OP_WRITE : OP_READ;
        r_addr  <= mem_addr;
        r_wdata <= mem_wdata;
      end else begin
        r_op    <= OP_FETCH;
        r_addr  <= pc;
      end
    end
  end

  // Read data assembly: first received byte is the low half
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= 16'd0;
      r_rx_hi <= 1'b0;
    end else if (w_accept) begin
      r_rx_hi <= 1'b0;
    end else if (w_rx_hs && (r_op == OP_READ)) begin
      if (r_rx_hi) r_rdata[15:8] <= bus.rx_data;
      else         r_rdata[7:0]  <= bus.rx_data;
      r_rx_hi <= ~r_rx_hi;
    end
  end

  // Transmit byte select: command, address low/high, write data low/high
  always_comb begin
    bus.tx_data = 8'h00;
    case (r_state)
      S_CMD:      bus.tx_data = {6'd0, r_op};
      S_ADDR_LO:  bus.tx_data = r_addr[7:0];
      S_ADDR_HI:  bus.tx_data = r_addr[15:8];
      S_WDATA_LO: bus.tx_data = r_wdata[7:0];
      S_WDATA_HI: bus.tx_data = r_wdata[15:8];
      default:    bus.tx_data = 8'h00;
    endcase
  end

  assign bus.tx_valid = w_tx_state;
  assign instr_shift  = w_rx_hs && w_fetch;
  assign mem_rdata    = r_rdata;
  assign fetch_done   = (r_state == S_DONE) && w_fetch;
  assign mem_done     = (r_state == S_DONE) && !w_fetch;
  assign busy         = (r_state != S_IDLE);
  assign halted       = (r_state == S_HALT);
  assign error        = (r_state == S_ERROR);

endmodule

// File: tb/tb_serial_bus_sequencer.sv
// tb/tb_serial_bus_sequencer.sv - self-checking bench for serial_bus_sequencer
module tb_serial_bus_sequencer;
  localparam int TIMEOUT = 4;
  localparam logic [1:0] K_FETCH = 2'd1;
  localparam logic [1:0] K_READ  = 2'd2;
  localparam logic [1:0] K_WRITE = 2'd3;

  typedef struct {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [7:0]  rx0;
    logic [7:0]  rx1;
    int          gap;
    int          ready_mode;
    int          lat;
    logic [15:0] exp_rdata;
  } vec_t;

  typedef struct {
    bit          is_fetch;
    bit          chk_data;
    logic [15:0] rdata;
  } done_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_req = 1'b0;
  logic [15:0] pc = 16'd0;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [15:0] mem_addr = 16'd0;
  logic [15:0] mem_wdata = 16'd0;
  logic        instr_shift;
  logic        instr_done;
  logic        instr_halt;
  logic        instr_err;
  logic [15:0] mem_rdata;
  logic        fetch_done;
  logic        mem_done;
  logic        busy;
  logic        halted;
  logic        error;

  serial_bus_sequencer_if bus();

  serial_bus_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .pc          (pc),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .bus         (bus),
    .instr_shift (instr_shift),
    .instr_done  (instr_done),
    .instr_halt  (instr_halt),
    .instr_err   (instr_err),
    .mem_rdata   (mem_rdata),
    .fetch_done  (fetch_done),
    .mem_done    (mem_done),
    .busy        (busy),
    .halted      (halted),
    .error       (error)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_tx[$];
  done_t      exp_done[$];
  logic [7:0] rx_q[$];
  int         end_q[$];
  int         rsp_gap = 0;
  int         ready_mode = 0;
  int         shift_cnt = 0;
  int         n_pass = 0;
  int         n_total = 0;
  done_t      mon_d;
  logic [7:0] mon_b;
  vec_t       vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitor: pops expected bytes on handshakes and expected completions on done pulses
  always @(negedge clk) begin
    if (rst) begin
      if (instr_shift) shift_cnt++;
      if (bus.tx_valid && bus.tx_ready) begin
        check("tx_byte_expected", exp_tx.size() != 0, 1);
        if (exp_tx.size() != 0) begin
          mon_b = exp_tx.pop_front();
          check("tx_byte", bus.tx_data, mon_b);
        end
      end
      if (mem_done || fetch_done) begin
        check("done_expected", exp_done.size() != 0, 1);
        if (exp_done.size() != 0) begin
          mon_d = exp_done.pop_front();
          check("done_is_fetch", fetch_done, mon_d.is_fetch);
          check("done_is_mem", mem_done, !mon_d.is_fetch);
          if (mon_d.chk_data) check("mem_rdata", mem_rdata, mon_d.rdata);
        end
      end
    end
  end

  // Bus/instruction-register responder: supplies rx bytes and the fetch verdict while receiving
  initial begin : responder
    int wait_cnt;
    int code;
    wait_cnt = 0;
    bus.tx_ready = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    instr_done = 1'b0;
    instr_halt = 1'b0;
    instr_err = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
      instr_done = 1'b0;
      instr_halt = 1'b0;
      instr_err = 1'b0;
      if (ready_mode == 0)      bus.tx_ready = 1'b1;
      else if (ready_mode == 1) bus.tx_ready = ~bus.tx_ready;
      else                      bus.tx_ready = 1'b0;
      if (rst && busy && !bus.tx_valid && !mem_done && !fetch_done && !halted && !error) begin
        if (rx_q.size() > 0) begin
          if (wait_cnt >= rsp_gap) begin
            bus.rx_valid = 1'b1;
            bus.rx_data = rx_q.pop_front();
            wait_cnt = 0;
          end else begin
            wait_cnt++;
          end
        end else if (end_q.size() > 0) begin
          code = end_q.pop_front();
          instr_done = (code == 1);
          instr_halt = (code == 2);
          instr_err = (code == 3);
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_txn(input logic [1:0] kind, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [7:0] rx0, input logic [7:0] rx1, input logic [15:0] rdata);
    exp_tx.push_back({6'd0, kind});
    exp_tx.push_back(addr[7:0]);
    exp_tx.push_back(addr[15:8]);
    if (kind == K_WRITE) begin
      exp_tx.push_back(wdata[7:0]);
      exp_tx.push_back(wdata[15:8]);
    end else begin
      rx_q.push_back(rx0);
      rx_q.push_back(rx1);
    end
    if (kind == K_FETCH) end_q.push_back(1);
    exp_done.push_back('{kind == K_FETCH, kind == K_READ, rdata});
  endtask

  task automatic drive_req(input logic [1:0] kind, input logic [15:0] addr, input logic [15:0] wdata);
    if (kind == K_FETCH) begin
      fetch_req = 1'b1;
      pc = addr;
    end else begin
      mem_req = 1'b1;
      mem_we = (kind == K_WRITE);
      mem_addr = addr;
      mem_wdata = wdata;
    end
  endtask

  task automatic wait_done(output bit seen, output int cyc);
    seen = 1'b0;
    for (cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      if (mem_done || fetch_done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_txn(input vec_t v);
    bit seen;
    int cyc;
    int sh0;
    rsp_gap = v.gap;
    ready_mode = v.ready_mode;
    tick();
    sh0 = shift_cnt;
    push_txn(v.kind, v.addr, v.wdata, v.rx0, v.rx1, v.exp_rdata);
    drive_req(v.kind, v.addr, v.wdata);
    wait_done(seen, cyc);
    check("done_seen", seen, 1);
    if (v.lat != 0) check("done_latency", cyc, v.lat);
    tick();
    mem_req = 1'b0;
    fetch_req = 1'b0;
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("tx_queue_drained", exp_tx.size(), 0);
    if (v.kind == K_FETCH) check("instr_shift_count", shift_cnt - sh0, 2);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    mem_req = 1'b0;
    fetch_req = 1'b0;
    exp_tx.delete();
    exp_done.delete();
    rx_q.delete();
    end_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit seen;
    int cyc;
    int sh0;
    vec_t vr;

    vecs[0] = '{K_WRITE, 16'h00A0, 16'h1234, 8'h00, 8'h00, 0, 0, 6,  16'h0000};
    vecs[1] = '{K_READ,  16'h0010, 16'h0000, 8'hCD, 8'hAB, 0, 0, 6,  16'hABCD};
    vecs[2] = '{K_READ,  16'hFFFF, 16'h0000, 8'h00, 8'hFF, 1, 0, 8,  16'hFF00};
    vecs[3] = '{K_WRITE, 16'h5A5A, 16'hFFFF, 8'h00, 8'h00, 0, 0, 6,  16'h0000};
    vecs[4] = '{K_FETCH, 16'h0004, 16'h0000, 8'h11, 8'h22, 0, 0, 7,  16'h0000};
    vecs[5] = '{K_READ,  16'h8001, 16'h0000, 8'h5A, 8'hA5, 3, 0, 12, 16'hA55A};
    vecs[6] = '{K_FETCH, 16'hBEEF, 16'h0000, 8'h33, 8'h44, 2, 0, 11, 16'h0000};
    vecs[7] = '{K_WRITE, 16'h0F0F, 16'hC3C3, 8'h00, 8'h00, 0, 1, 0,  16'h0000};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_flags", {busy, halted, error, mem_done, fetch_done, instr_shift}, 0);
    check("rst_mem_rdata", mem_rdata, 0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {busy, bus.tx_valid}, 0);
    tick();

    for (int i = 0; i < 8; i++) do_txn(vecs[i]);

    // Simultaneous requests: data access first, then the fetch
    ready_mode = 0;
    rsp_gap = 0;
    tick();
    push_txn(K_READ, 16'h0020, 16'h0000, 8'h78, 8'h56, 16'h5678);
    push_txn(K_FETCH, 16'h0004, 16'h0000, 8'h11, 8'h22, 16'h0000);
    mem_req = 1'b1;
    mem_we = 1'b0;
    mem_addr = 16'h0020;
    fetch_req = 1'b1;
    pc = 16'h0004;
    wait_done(seen, cyc);
    check("both_first_mem_done", mem_done, 1);
    tick();
    mem_req = 1'b0;
    wait_done(seen, cyc);
    check("both_second_fetch_done", fetch_done, 1);
    tick();
    fetch_req = 1'b0;
    check("both_tx_drained", exp_tx.size(), 0);

    // Reset while the address high byte is on the bus
    tick();
    push_txn(K_READ, 16'h0030, 16'h0000, 8'hEE, 8'hEE, 16'h0000);
    drive_req(K_READ, 16'h0030, 16'h0000);
    repeat (4) @(negedge clk);
    check("pre_reset_addr_hi", {bus.tx_valid, bus.tx_data}, 9'h100);
    #1;
    rst = 1'b0;
    #1;
    check("async_rst_tx", {bus.tx_valid, bus.tx_data}, 0);
    check("async_rst_flags", {busy, mem_done, fetch_done, instr_shift}, 0);
    check("async_rst_mem_rdata", mem_rdata, 0);
    do_reset();
    vr = '{K_READ, 16'h0031, 16'h0000, 8'h99, 8'h88, 0, 0, 6, 16'h8899};
    do_txn(vr);

    // Fetch ending in a halt verdict
    tick();
    sh0 = shift_cnt;
    exp_tx.push_back(8'h01);
    exp_tx.push_back(8'h00);
    exp_tx.push_back(8'h01);
    rx_q.push_back(8'h01);
    rx_q.push_back(8'h02);
    end_q.push_back(2);
    fetch_req = 1'b1;
    pc = 16'h0100;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      seen = halted;
    end
    check("halt_reached", seen, 1);
    check("halt_shift_count", shift_cnt - sh0, 2);
    check("halt_error_low", error, 0);
    tick();
    fetch_req = 1'b0;
    mem_req = 1'b1;
    mem_we = 1'b1;
    repeat (5) @(negedge clk);
    check("halt_sticky", {halted, busy, bus.tx_valid}, 3'b110);
    tick();
    mem_req = 1'b0;
    check("halt_tx_drained", exp_tx.size(), 0);
    do_reset();
    check("halt_cleared_by_reset", halted, 0);

    // Fetch ending in an illegal-opcode verdict
    tick();
    sh0 = shift_cnt;
    exp_tx.push_back(8'h01);
    exp_tx.push_back(8'h00);
    exp_tx.push_back(8'h02);
    rx_q.push_back(8'h7F);
    end_q.push_back(3);
    fetch_req = 1'b1;
    pc = 16'h0200;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      seen = error;
    end
    check("instr_err_error", seen, 1);
    check("instr_err_not_halted", halted, 0);
    check("instr_err_shift_count", shift_cnt - sh0, 1);
    do_reset();

    // Bus never accepts the command byte: timeout after TIMEOUT stalled cycles
    ready_mode = 2;
    tick();
    mem_req = 1'b1;
    mem_we = 1'b1;
    mem_addr = 16'h1111;
    mem_wdata = 16'h2222;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (c == 4) begin
        check("timeout_not_yet", error, 0);
        check("timeout_cmd_held", {bus.tx_valid, bus.tx_data}, 9'h103);
      end
      if (c == 5) check("timeout_error", error, 1);
    end
    tick();
    mem_req = 1'b0;
    fetch_req = 1'b1;
    ready_mode = 0;
    repeat (6) @(negedge clk);
    check("error_sticky", {error, halted, bus.tx_valid, fetch_done}, 4'b1000);
    tick();
    fetch_req = 1'b0;
    do_reset();
    check("error_cleared_by_reset", error, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
